// File: rtl/cfi_trace_packer.sv
// cfi_trace_packer: packs up to four trace items into one 128-bit CFI_FIFO beat.
// A beat is sent on a mismatched CID, a control header, a full beat, or an idle timeout.
module cfi_trace_packer #(
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [3:0]   in_hdr,
    input  logic         in_state,
    input  logic [31:0]  in_cid,
    input  logic [31:0]  in_data,
    output logic [4:0]   out_ins,
    output logic [15:0]  out_inh,
    output logic [31:0]  out_inc,
    output logic [127:0] out_ind,
    output logic [15:0]  beat_cnt,
    output logic [7:0]   drop_cnt
);
    logic [2:0]   cnt_q, cnt_d;
    logic [31:0]  cid_q, cid_d;
    logic [15:0]  hdr_q, hdr_d, m_hdr, e_hdr;
    logic [127:0] dat_q, dat_d, m_dat, e_dat;
    logic [3:0]   st_q, st_d, m_st, e_st;
    logic [31:0]  e_cid;
    logic [7:0]   idle_q, idle_d;
    logic         fp_q, fp_d;
    logic         acc, ctl, mism, full, idle_hit, emit;

    assign acc      = in_valid && in_hdr != 4'd0 && in_hdr <= 4'd6;
    assign ctl      = in_hdr >= 4'd3 && in_hdr <= 4'd6;
    assign mism     = acc && !fp_q && cnt_q != 3'd0 && in_cid != cid_q;
    assign full     = cnt_q == 3'd3;
    assign idle_hit = FLUSH_TIMEOUT != 0 && !acc && !fp_q && cnt_q != 3'd0 &&
                      idle_q + 8'd1 == 8'(FLUSH_TIMEOUT);

    // m_* is the accumulator with the incoming item merged into slot cnt_q
    always_comb begin
        m_hdr = hdr_q;
        m_dat = dat_q;
        m_st  = st_q;
        m_hdr[{cnt_q[1:0], 2'b00} +: 4]  = in_hdr;
        m_dat[{cnt_q[1:0], 5'b00000} +: 32] = in_data;
        m_st[cnt_q[1:0]] = in_state;
        emit   = fp_q || mism || idle_hit;
        e_hdr  = hdr_q;
        e_dat  = dat_q;
        e_st   = st_q;
        e_cid  = cid_q;
        cnt_d  = cnt_q;
        cid_d  = cid_q;
        hdr_d  = hdr_q;
        dat_d  = dat_q;
        st_d   = st_q;
        fp_d   = 1'b0;
        idle_d = cnt_q != 3'd0 ? idle_q + 8'd1 : 8'd0;
        if (acc && (fp_q || mism)) begin
            cnt_d  = 3'd1;
            cid_d  = in_cid;
            hdr_d  = {12'd0, in_hdr};
            dat_d  = {96'd0, in_data};
            st_d   = {3'd0, in_state};
            fp_d   = ctl;
            idle_d = 8'd0;
        end else if (acc && (ctl || full)) begin
            emit   = 1'b1;
            e_hdr  = m_hdr;
            e_dat  = m_dat;
            e_st   = m_st;
            e_cid  = in_cid;
            cnt_d  = 3'd0;
            cid_d  = in_cid;
            hdr_d  = '0;
            dat_d  = '0;
            st_d   = '0;
            idle_d = 8'd0;
        end else if (acc) begin
            cnt_d  = cnt_q + 3'd1;
            cid_d  = in_cid;
            hdr_d  = m_hdr;
            dat_d  = m_dat;
            st_d   = m_st;
            idle_d = 8'd0;
        end else if (fp_q || idle_hit) begin
            cnt_d  = 3'd0;
            hdr_d  = '0;
            dat_d  = '0;
            st_d   = '0;
            idle_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cid_q    <= '0;
            hdr_q    <= '0;
            dat_q    <= '0;
            st_q     <= '0;
            fp_q     <= 1'b0;
            idle_q   <= '0;
            out_ins  <= '0;
            out_inh  <= '0;
            out_inc  <= '0;
            out_ind  <= '0;
            beat_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            cnt_q   <= cnt_d;
            cid_q   <= cid_d;
            hdr_q   <= hdr_d;
            dat_q   <= dat_d;
            st_q    <= st_d;
            fp_q    <= fp_d;
            idle_q  <= idle_d;
            out_ins <= emit ? {1'b1, e_st} : 5'd0;
            out_inh <= emit ? e_hdr : 16'd0;
            out_ind <= emit ? e_dat : 128'd0;
            if (emit) out_inc <= e_cid;
            if (emit) beat_cnt <= beat_cnt + 16'd1;
            if (in_valid && !acc && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_cfi_trace_packer.sv
// tb_cfi_trace_packer: directed and random items checked against a queue-based packing model.
module tb_cfi_trace_packer;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [3:0]   in_hdr = '0;
    logic         in_state = 1'b0;
    logic [31:0]  in_cid = '0;
    logic [31:0]  in_data = '0;
    logic [4:0]   out_ins;
    logic [15:0]  out_inh;
    logic [31:0]  out_inc;
    logic [127:0] out_ind;
    logic [15:0]  beat_cnt;
    logic [7:0]   drop_cnt;

    cfi_trace_packer #(.FLUSH_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_hdr(in_hdr),
        .in_state(in_state), .in_cid(in_cid), .in_data(in_data),
        .out_ins(out_ins), .out_inh(out_inh), .out_inc(out_inc), .out_ind(out_ind),
        .beat_cnt(beat_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  h;
        logic        s;
        logic [31:0] c;
        logic [31:0] d;
    } item_t;

    item_t        q[$];
    logic [31:0]  m_cid;
    logic         m_fp;
    int           m_idle;
    logic [15:0]  m_beat;
    logic [7:0]   m_drop;
    logic [4:0]   e_ins;
    logic [15:0]  e_inh;
    logic [31:0]  e_inc;
    logic [127:0] e_ind;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_cid = '0; m_fp = 1'b0; m_idle = 0; m_beat = '0; m_drop = '0;
        e_ins = '0; e_inh = '0; e_inc = '0; e_ind = '0;
    endfunction

    function automatic void send(input logic [31:0] cid);
        e_ins[4] = 1'b1;
        foreach (q[k]) begin
            e_inh[k*4 +: 4]   = q[k].h;
            e_ind[k*32 +: 32] = q[k].d;
            e_ins[k]          = q[k].s;
        end
        e_inc = cid;
        m_beat++;
        q.delete();
    endfunction

    function automatic void model(input logic v, input logic [3:0] h, input logic s,
                                  input logic [31:0] c, input logic [31:0] d);
        logic a, ctl;
        item_t it;
        it = '{h: h, s: s, c: c, d: d};
        e_ins = '0; e_inh = '0; e_ind = '0;
        a   = v && h >= 1 && h <= 6;
        ctl = h >= 3 && h <= 6;
        if (v && !a && m_drop != 8'hff) m_drop++;
        if (m_fp) begin
            send(m_cid);
            m_fp = 1'b0;
            m_idle = 0;
            if (a) begin
                q.push_back(it); m_cid = c; m_fp = ctl;
            end
        end else if (a) begin
            m_idle = 0;
            if (q.size() > 0 && c != m_cid) begin
                send(m_cid);
                q.push_back(it); m_cid = c; m_fp = ctl;
            end else begin
                q.push_back(it); m_cid = c;
                if (ctl || q.size() == 4) send(c);
            end
        end else if (q.size() > 0 && T != 0) begin
            m_idle++;
            if (m_idle == T) begin
                send(m_cid);
                m_idle = 0;
            end
        end
    endfunction

    task automatic step(input logic v, input logic [3:0] h, input logic s,
                        input logic [31:0] c, input logic [31:0] d);
        in_valid = v; in_hdr = h; in_state = s; in_cid = c; in_data = d;
        model(v, h, s, c, d);
        @(posedge clk);
        #1;
        chk("beat", {out_ins, out_inh, out_ind}, {e_ins, e_inh, e_ind});
        chk("inc", out_inc, e_inc);
        chk("beat_cnt", beat_cnt, m_beat);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [15:0] b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {out_ins, out_inh, out_inc, out_ind, beat_cnt, drop_cnt}, '0);
        rst_n = 1'b1;

        // dropped items interleaved with three hdr-2 items
        step(1'b1, 4'd2, 1'b1, 32'h50, 32'hB0);
        step(1'b1, 4'd0, 1'b0, 32'h99, 32'hEE);
        step(1'b1, 4'd2, 1'b0, 32'h50, 32'hB1);
        step(1'b1, 4'd9, 1'b1, 32'h50, 32'hEF);
        step(1'b1, 4'd2, 1'b1, 32'h50, 32'hB2);
        chk("drop2", {out_ins[4], drop_cnt}, {1'b0, 8'd2});

        // reset mid-beat discards the three stored items
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_mid", {out_ins, out_inh, out_inc, out_ind, beat_cnt, drop_cnt}, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        chk("no_beat_after_rst", beat_cnt, 16'd0);

        // four items fill a beat
        step(1'b1, 4'd2, 1'b1, 32'h10, 32'hA0);
        step(1'b1, 4'd2, 1'b0, 32'h10, 32'hA1);
        step(1'b1, 4'd2, 1'b1, 32'h10, 32'hA2);
        step(1'b1, 4'd2, 1'b0, 32'h10, 32'hA3);
        chk("full_beat", {out_ins, out_inh, out_inc, out_ind},
            {5'h15, 16'h2222, 32'h10, 128'h000000A3_000000A2_000000A1_000000A0});

        // cid change emits the partial beat
        step(1'b1, 4'd2, 1'b0, 32'h10, 32'hC0);
        step(1'b1, 4'd2, 1'b0, 32'h10, 32'hC1);
        step(1'b1, 4'd2, 1'b1, 32'h20, 32'hC2);
        chk("cid_change", {out_ins[4], out_inh, out_inc}, {1'b1, 16'h0022, 32'h10});
        idle(20);

        // control header closes the beat including itself
        step(1'b1, 4'd1, 1'b0, 32'h10, 32'hD0);
        step(1'b1, 4'd6, 1'b0, 32'h10, 32'hD1);
        chk("ctl_close", {out_ins[4], out_inh}, {1'b1, 16'h0061});

        // cid change on a control item: two beats back to back
        b0 = beat_cnt;
        step(1'b1, 4'd2, 1'b0, 32'h10, 32'hE0);
        step(1'b1, 4'd2, 1'b0, 32'h10, 32'hE1);
        step(1'b1, 4'd4, 1'b1, 32'h30, 32'hE2);
        chk("ctl_mism_a", {out_ins[4], out_inh, out_inc}, {1'b1, 16'h0022, 32'h10});
        idle(1);
        chk("ctl_mism_b", {out_ins, out_inh, out_inc}, {5'h11, 16'h0004, 32'h30});
        chk("ctl_mism_cnt", beat_cnt, b0 + 16'd2);

        // idle timeout flushes 16 cycles after acceptance
        step(1'b1, 4'd2, 1'b0, 32'h10, 32'hF0);
        idle(15);
        chk("idle_early", out_ins[4], 1'b0);
        idle(1);
        chk("idle_flush", {out_ins[4], out_inh}, {1'b1, 16'h0002});

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 8) idle($urandom_range(1, 20));
            else step($urandom_range(0, 99) < 80,
                      $urandom_range(0, 99) < 75 ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0 ? 32'h20 : 32'h10,
                      $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cfi_trace_packer.md
# cfi_trace_packer

Transmit-side packer for the CFI trace link. It takes a stream of single trace items (4-bit header, 32-bit data, 1-bit state, 32-bit context ID) from the trace-decode front end. It packs up to four items into one 128-bit beat in the slot format consumed by `CFI_FIFO`, and pushes each beat on the `ins/inh/inc/ind` bus with `ins[4]` as the one-cycle valid strobe. The link has no backpressure, so the packer always accepts one item per cycle.

## Interface
- `FLUSH_TIMEOUT`, 16: idle cycles before a partial beat is flushed. 0 disables the timeout. Legal range 0–255.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: the item on `in_*` is presented this cycle. It is always accepted.
- `in_hdr`  in  4: item header. Header 0 and headers 7–15 are dropped.
- `in_state`  in  1: item state bit.
- `in_cid`  in  32: item context ID.
- `in_data`  in  32: item payload.
- `out_ins`  out  5: bit 4 is the beat strobe; bits [3:0] are the per-slot state bits.
- `out_inh`  out  16: per-slot headers; slot k occupies [4k+3:4k].
- `out_inc`  out  32: context ID shared by every slot in the beat.
- `out_ind`  out  128: per-slot data; slot k occupies [32k+31:32k].
- `beat_cnt`  out  16: number of beats emitted; wraps at 2^16.
- `drop_cnt`  out  8: number of dropped items; saturates at 255.

## Operation
- The accumulator holds `slot_cnt` (0–4), `acc_cid`, and four header/data/state slots. Slots fill from 0 upward. Unfilled slots are header 0, data 0, state 0, which `CFI_FIFO` skips.
- An item is *accepted* when `in_valid`=1 and `in_hdr` is in 1–6. A dropped item increments `drop_cnt` and otherwise has no effect: no slot, no flush, and the idle counter is not reset.
- Accepted item, cases in priority order. Here ctl means `in_hdr` is 3, 4, 5 or 6, and mismatch means `slot_cnt`>0 and `in_cid`≠`acc_cid`.
  - mismatch and ctl: emit the current accumulator. The item becomes slot 0 of a new accumulator, and `flush_pend` is set.
  - mismatch only: emit the current accumulator. The item becomes slot 0 of a new accumulator with `acc_cid`=`in_cid`.
  - ctl only: emit the accumulator including the item, then clear the accumulator.
  - neither, and the item fills slot 3: emit the full beat, then clear the accumulator.
  - otherwise: store the item in slot `slot_cnt` and increment `slot_cnt`.
- `flush_pend`: in the next cycle, the one-slot beat is emitted unconditionally. An item accepted in that same cycle starts a fresh accumulator at slot 0 and is compared against its own CID, with no mismatch.
- Idle flush: `idle_cnt` counts consecutive cycles with no accepted item while `slot_cnt`>0. When it reaches `FLUSH_TIMEOUT`, the partial beat is emitted and both `slot_cnt` and `idle_cnt` clear. `idle_cnt` clears on any accepted item. This flush never coincides with an accepted item.
- At most one beat is emitted per cycle. The output registers hold a snapshot, so the accumulator refills in the same cycle a beat is emitted.
- `beat_cnt` increments once per emitted beat.

## Timing
- Reset (asynchronous assert, synchronous release): every output is 0, `slot_cnt`=0, `acc_cid`=0, `flush_pend`=0, `idle_cnt`=0.
- Latency: an item accepted at edge N that triggers an emit appears with `out_ins[4]`=1 during cycle N+1, i.e. after edge N.
- The strobe is high for exactly one cycle. On a cycle with no emit, `out_ins`, `out_inh` and `out_ind` are 0; `out_inc` holds its last value.
- A reset asserted mid-beat discards the partial accumulator and any pending flush. No beat is emitted for them.
- Beat order equals item order; no item is reordered across a beat boundary.

## Test plan
- Four items, hdr 2, cid 0x10, data 0xA0..0xA3, state 1,0,1,0, on consecutive cycles → one strobe one cycle after the 4th item: `out_inh`=0x2222, `out_ind`=0x000000A3_000000A2_000000A1_000000A0, `out_ins`=0x15, `out_inc`=0x10.
- Two hdr-2 items with cid 0x10, then one with cid 0x20 → beat `out_inh`=0x0022, `out_inc`=0x10. The cid-0x20 item sits in slot 0 of the next beat.
- One hdr-1 item followed by one hdr-6 item, both with the same cid → a single beat with `out_inh`=0x0061, emitted the cycle after the hdr-6 item.
- Two hdr-2 items with cid 0x10, then hdr 4 with cid 0x30 → beat `out_inh`=0x0022, `out_inc`=0x10. Next cycle, beat `out_inh`=0x0004, `out_inc`=0x30. `beat_cnt` advances by 2.
- With `FLUSH_TIMEOUT`=16: one hdr-2 item then idle → strobe exactly 16 cycles after acceptance, `out_inh`=0x0002.
- Items with hdr 0 and hdr 9, interleaved with three hdr-2 items → no flush from the dropped items, `drop_cnt`=2. Asserting `rst_n`=0 mid-beat clears all outputs, and no beat follows.
